// File: rtl/control_unit.sv
// FETCH/EXEC/HALT sequencer for the single-cycle microcontroller datapath.
// Optional retired-instruction counter enabled by CONTROL_UNIT_INSTR_COUNT_EN.
module control_unit #(
    parameter logic [5:0] HALT_OPCODE = 6'b111111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  Opcode,
    input  logic        z,
    input  logic        start,
    output logic        s_inc,
    output logic        s_inm,
    output logic        we3,
    output logic        wez,
    output logic [2:0]  Op,
    output logic        pc_en,
    output logic        halted,
    output logic        illegal,
    output logic [15:0] instr_count
);

    typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

    state_t state, state_nxt;

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_nxt;
    end

    // Outputs are held at their reset values while reset is high, so a
    // start arriving alongside reset in HALT cannot move the PC.
    always_comb begin
        state_nxt = state;
        s_inc     = 1'b1;
        s_inm     = 1'b0;
        we3       = 1'b0;
        wez       = 1'b0;
        Op        = 3'b000;
        pc_en     = 1'b0;
        halted    = 1'b0;
        illegal   = 1'b0;
        if (!reset) begin
            case (state)
                FETCH: state_nxt = EXEC;
                EXEC: begin
                    state_nxt = FETCH;
                    pc_en     = 1'b1;
                    if (Opcode == HALT_OPCODE) begin
                        pc_en     = 1'b0;
                        state_nxt = HALT;
                    end else if (Opcode[5:4] == 2'b00) begin
                        Op  = Opcode[2:0];
                        we3 = 1'b1;
                        wez = 1'b1;
                    end else if (Opcode[5:4] == 2'b01) begin
                        s_inm = 1'b1;
                        we3   = 1'b1;
                    end else begin
                        case (Opcode)
                            6'b100000: s_inc = 1'b0;
                            6'b100001: s_inc = ~z;
                            6'b100010: s_inc = z;
                            default:   illegal = 1'b1;
                        endcase
                    end
                end
                HALT: begin
                    halted = 1'b1;
                    if (start) begin
                        pc_en     = 1'b1;
                        state_nxt = FETCH;
                    end
                end
                default: state_nxt = FETCH;
            endcase
        end
    end

`ifdef CONTROL_UNIT_INSTR_COUNT_EN
    logic [15:0] cnt;

    // pc_en in EXEC marks a retired instruction; halt never sets it there.
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= 16'h0000;
        else if (state == EXEC && pc_en && cnt != 16'hFFFF)
            cnt <= cnt + 16'd1;
    end

    assign instr_count = cnt;
`else
    assign instr_count = 16'h0000;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle compare against an instruction-level
// model plus hand-computed literal checks from the test plan.
module tb_control_unit;

    logic        clk = 1'b0, reset = 1'b1, z = 1'b0, start = 1'b0;
    logic [5:0]  Opcode = 6'd0;
    logic        s_inc, s_inm, we3, wez, pc_en, halted, illegal;
    logic [2:0]  Op;
    logic [15:0] instr_count;

    control_unit dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .z(z), .start(start),
        .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .Op(Op),
        .pc_en(pc_en), .halted(halted), .illegal(illegal), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

`ifdef CONTROL_UNIT_INSTR_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct packed {
        logic       s_inc, s_inm, we3, wez;
        logic [2:0] op;
        logic       pc_en, halted, illegal;
    } exp_t;

    int checks = 0, failures = 0;
    bit run = 1'b0;
    int m_ph = 0;   // 0 = waiting for memory, 1 = executing, 2 = stopped
    int m_cnt = 0;
    exp_t m_e, c_e, c_got;

    // Instruction-level expectation taken straight from the opcode table.
    function automatic exp_t model(int ph, logic [5:0] o, logic zz, logic st, logic rst);
        exp_t e = '{s_inc: 1'b1, default: '0};
        if (rst) return e;
        if (ph == 2) begin
            e.halted = 1'b1;
            e.pc_en  = st;
        end else if (ph == 1 && o != 6'h3F) begin
            e.pc_en = 1'b1;
            if (o < 6'd16) begin
                e.op = o[2:0]; e.we3 = 1'b1; e.wez = 1'b1;
            end else if (o < 6'd32) begin
                e.s_inm = 1'b1; e.we3 = 1'b1;
            end else if (o == 6'd32) e.s_inc = 1'b0;
            else if (o == 6'd33) e.s_inc = ~zz;
            else if (o == 6'd34) e.s_inc = zz;
            else e.illegal = 1'b1;
        end
        return e;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_ph = 0; m_cnt = 0;
        end else begin
            m_e = model(m_ph, Opcode, z, start, 1'b0);
            if (m_ph == 1 && m_e.pc_en && m_cnt < 65535) m_cnt++;
            if (m_ph == 0)      m_ph = 1;
            else if (m_ph == 1) m_ph = (Opcode == 6'h3F) ? 2 : 0;
            else                m_ph = start ? 0 : 2;
        end
    end

    always @(negedge clk) begin
        if (run) begin
            c_e   = model(m_ph, Opcode, z, start, reset);
            c_got = '{s_inc, s_inm, we3, wez, Op, pc_en, halted, illegal};
            checks++;
            if (c_got !== c_e) begin
                failures++;
                $display("FAIL model_outputs t=%0t got=%b exp=%b", $time, c_got, c_e);
            end
            checks++;
            if (instr_count !== (CNT_EN ? m_cnt[15:0] : 16'h0000)) begin
                failures++;
                $display("FAIL model_count t=%0t got=%0d exp=%0d", $time, instr_count,
                         CNT_EN ? m_cnt : 0);
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic set(input logic [5:0] o, input logic zz, input logic st);
        Opcode = o; z = zz; start = st;
        #2;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch();
        set(6'd0, 1'b0, 1'b0);
        nxt();
    endtask

    logic [7:0] jtab [6] = '{8'b100001_1_0, 8'b100001_0_1, 8'b100010_1_1,
                             8'b100010_0_0, 8'b100000_0_0, 8'b100000_1_0};

    initial begin
        logic [7:0] jv;
        nxt();
        run = 1'b1;
        set(6'd0, 1'b0, 1'b1);
        chk("reset_vals", {s_inc, s_inm, we3, wez, Op, pc_en, halted, illegal}, 16'b1000_0000_00);
        chk("reset_cnt", instr_count, 16'h0000);
        nxt();
        reset = 1'b0;

        set(6'b000010, 1'b0, 1'b0);
        chk("alu_fetch", {pc_en, we3, wez}, 16'b000);
        nxt();
        set(6'b000010, 1'b0, 1'b0);
        chk("alu_exec", {we3, wez, Op, pc_en, s_inc}, 16'b11_010_11);
        nxt();

        fetch();
        set(6'b010000, 1'b0, 1'b0);
        chk("ldi_exec", {s_inm, we3, wez, pc_en}, 16'b1101);
        nxt();

        for (int i = 0; i < 6; i++) begin
            jv = jtab[i];
            fetch();
            set(jv[7:2], jv[1], 1'b0);
            chk($sformatf("jump%0d_sinc", i), s_inc, jv[0]);
            chk($sformatf("jump%0d_en", i), {pc_en, we3, wez}, 16'b100);
            nxt();
        end

        fetch();
        set(6'b100111, 1'b0, 1'b0);
        chk("illegal_exec", {illegal, pc_en, we3, wez}, 16'b1100);
        nxt();
        set(6'd0, 1'b0, 1'b0);
        chk("illegal_clear", illegal, 16'h0);
        nxt();

        set(6'b111111, 1'b0, 1'b0);
        chk("halt_exec", {pc_en, halted}, 16'b00);
        nxt();
        for (int i = 0; i < 5; i++) begin
            set(6'b111111, 1'b0, 1'b0);
            chk($sformatf("halt_idle%0d", i), {halted, pc_en, we3, wez}, 16'b1000);
            nxt();
        end
        set(6'b111111, 1'b0, 1'b1);
        chk("halt_resume", {halted, pc_en, s_inc}, 16'b111);
        nxt();
        set(6'b111111, 1'b0, 1'b1);
        chk("resume_fetch", {halted, pc_en}, 16'b00);
        nxt();
        set(6'b111111, 1'b0, 1'b1);
        chk("rehalt_exec", {halted, pc_en}, 16'b00);
        nxt();
        reset = 1'b1;
        set(6'b111111, 1'b0, 1'b1);
        chk("reset_in_halt", {halted, pc_en}, 16'b00);
        nxt();
        reset = 1'b0;
        set(6'd0, 1'b0, 1'b0);
        chk("post_reset_fetch", {halted, pc_en}, 16'b00);
        nxt();
        set(6'b000001, 1'b0, 1'b0);
        chk("post_reset_exec", {pc_en, we3}, 16'b11);
        nxt();

        reset = 1'b1;
        set(6'd0, 1'b0, 1'b0);
        nxt();
        reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            fetch();
            set(6'b000001, 1'b0, 1'b0);
            nxt();
            chk($sformatf("cnt_alu%0d", i), instr_count, CNT_EN ? 16'(i) : 16'h0000);
        end
        fetch();
        set(6'b111111, 1'b0, 1'b0);
        nxt();
        chk("cnt_halt", instr_count, CNT_EN ? 16'd3 : 16'h0000);
        chk("cnt_halted", halted, 16'h1);
        reset = 1'b1;
        set(6'b111111, 1'b0, 1'b0);
        nxt();
        reset = 1'b0;
        set(6'd0, 1'b0, 1'b0);
        chk("cnt_cleared", instr_count, 16'h0000);
        chk("cnt_fetch", {halted, pc_en}, 16'b00);
        nxt();

        @(negedge clk);
        run = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
